// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the TDM receive demultiplexer.
// Optional parity checking is enabled with the TDM_DEMUX_PARITY_EN macro.
package tdm_pkg;

  localparam int unsigned NCH_DEFAULT = 4;
  localparam int unsigned DW_DEFAULT  = 8;
  localparam int unsigned CH_W        = $clog2(NCH_DEFAULT);
  localparam int unsigned PAR_MAX_W   = 64;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  // Returns 1 when the vector fails even parity (odd number of ones)
  function automatic logic par_bad(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// Link-side bundle for tdm_demux: serial samples in, assembled frames out.
// din_par/par_err exist only when TDM_DEMUX_PARITY_EN is defined.
interface tdm_demux_if #(
  parameter int unsigned NCH = tdm_pkg::NCH_DEFAULT,
  parameter int unsigned DW  = tdm_pkg::DW_DEFAULT
);

  localparam int unsigned IDX_W = $clog2(NCH);

  logic [DW-1:0]     din;
  logic              din_valid;
  logic              frame_sync;
  logic [NCH*DW-1:0] dout;
  logic              dout_valid;
  logic [IDX_W-1:0]  ch_idx;
  logic              frame_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic              din_par;
  logic              par_err;

  modport master (
    output din, din_valid, frame_sync, din_par,
    input  dout, dout_valid, ch_idx, frame_err, par_err
  );

  modport slave (
    input  din, din_valid, frame_sync, din_par,
    output dout, dout_valid, ch_idx, frame_err, par_err
  );
`else
  modport master (
    output din, din_valid, frame_sync,
    input  dout, dout_valid, ch_idx, frame_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output dout, dout_valid, ch_idx, frame_err
  );
`endif

endinterface

// File: rtl/tdm_demux_demux_1to_n.sv
// 1:N slot-enable decoder producing shadow-buffer write enables.
module demux_1to_n
  import tdm_pkg::*;
#(
  parameter int unsigned N     = NCH_DEFAULT,
  parameter int unsigned SEL_W = $clog2(N)
) (
  input  logic [SEL_W-1:0] sel_i,
  input  logic             en_i,
  output logic [N-1:0]     we_c_o
);

  // One-hot enable for the selected slot when writing is enabled
  always_comb begin
    we_c_o = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (en_i && (sel_i == SEL_W'(k))) begin
        we_c_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM receive demultiplexer: assembles NCH serial samples into a parallel
// frame and flags misalignment. TDM_DEMUX_PARITY_EN adds per-frame parity.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEFAULT,
  parameter int unsigned DW  = DW_DEFAULT
) (
  input logic        clk,
  input logic        rst,
  tdm_demux_if.slave bus
);

  localparam int unsigned        IDX_W    = $clog2(NCH);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NCH - 1);

  state_e            state_q;
  logic [IDX_W-1:0]  ch_idx_q;
  logic [NCH*DW-1:0] shadow_q;
  logic [NCH*DW-1:0] shadow_d;
  logic [NCH*DW-1:0] dout_q;
  logic              dout_valid_q;
  logic              frame_err_q;
  logic [NCH-1:0]    slot_we_c;
  logic              wr_en_c;
  logic [IDX_W-1:0]  wr_idx_c;
  logic              samp_bad_c;

`ifdef TDM_DEMUX_PARITY_EN
  logic par_flag_q;
  logic par_err_q;

  assign samp_bad_c  = par_bad(PAR_MAX_W'({bus.din, bus.din_par}));
  assign bus.par_err = par_err_q;
`else
  assign samp_bad_c = 1'b0;
`endif

  // Write target: sync samples always land in slot 0, others follow the counter
  always_comb begin
    wr_en_c  = 1'b0;
    wr_idx_c = ch_idx_q;
    if (bus.frame_sync) begin
      wr_idx_c = '0;
      wr_en_c  = bus.din_valid;
    end else if ((state_q == COLLECT) && (ch_idx_q != '0)) begin
      wr_en_c = bus.din_valid;
    end
  end

  demux_1to_n #(
    .N     (NCH),
    .SEL_W (IDX_W)
  ) u_slot_dec (
    .sel_i  (wr_idx_c),
    .en_i   (wr_en_c),
    .we_c_o (slot_we_c)
  );

  // Shadow buffer with this cycle's sample merged in
  always_comb begin
    shadow_d = shadow_q;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (slot_we_c[k]) begin
        shadow_d[k*DW +: DW] = bus.din;
      end
    end
  end

  // Alignment FSM, slot counter and frame output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT;
      ch_idx_q     <= '0;
      shadow_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      par_flag_q   <= 1'b0;
      par_err_q    <= 1'b0;
`endif
    end else begin
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      par_err_q    <= 1'b0;
`endif
      if (bus.din_valid) begin
        shadow_q <= shadow_d;
        case (state_q)
          HUNT: begin
            if (bus.frame_sync) begin
              state_q  <= COLLECT;
              ch_idx_q <= IDX_W'(1);
`ifdef TDM_DEMUX_PARITY_EN
              par_flag_q <= samp_bad_c;
`endif
            end
          end
          COLLECT: begin
            if (bus.frame_sync) begin
              // Sync anywhere but slot 0 drops the partial frame and restarts
              frame_err_q <= (ch_idx_q != '0);
              ch_idx_q    <= IDX_W'(1);
`ifdef TDM_DEMUX_PARITY_EN
              par_flag_q  <= samp_bad_c;
`endif
            end else if (ch_idx_q == '0) begin
              // Expected sync never came: sample discarded, go hunting
              frame_err_q <= 1'b1;
              state_q     <= HUNT;
            end else if (ch_idx_q == LAST_IDX) begin
              dout_q       <= shadow_d;
              dout_valid_q <= 1'b1;
              ch_idx_q     <= '0;
`ifdef TDM_DEMUX_PARITY_EN
              par_err_q    <= par_flag_q | samp_bad_c;
`endif
            end else begin
              ch_idx_q <= ch_idx_q + IDX_W'(1);
`ifdef TDM_DEMUX_PARITY_EN
              par_flag_q <= par_flag_q | samp_bad_c;
`endif
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.ch_idx     = ch_idx_q;
  assign bus.frame_err  = frame_err_q;

`ifndef TDM_DEMUX_PARITY_EN
  logic unused_c;
  assign unused_c = samp_bad_c;
`endif

endmodule
